// File: rtl/ni_local.sv
// Local NI: core packets -> head/body/tail flits on router port 4; router port 4 flits -> core FIFO.
// Latency: injected flits registered one cycle after the decision; ejection FIFO is show-ahead, acks one cycle after pop.
// Backpressure: per-VC credits gate injection; full FIFO drops and sets sticky ej_ovf. Optional NI_STATS_EN adds packet counters.

`ifndef DATA_WIDTH
`define DATA_WIDTH 34
`endif
`ifndef VCH_WIDTH
`define VCH_WIDTH 4
`endif
`ifndef VCH_WIDTH_NUM
`define VCH_WIDTH_NUM 2
`endif

module ni_local #(
    parameter int ROUTERID  = 0,
    parameter int BUF_DEPTH = 4,
    parameter int LEN_W     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pkt_valid,
    input  logic [3:0]                    pkt_dst,
    input  logic [LEN_W-1:0]              pkt_len,
    output logic                          pkt_ready,
    input  logic                          pay_valid,
    input  logic [`DATA_WIDTH-3:0]        pay_data,
    output logic                          pay_ready,
    output logic [`DATA_WIDTH-1:0]        inj_data,
    output logic                          inj_valid,
    output logic [`VCH_WIDTH_NUM-1:0]     inj_vch,
    input  logic [`VCH_WIDTH-1:0]         inj_ack,
    input  logic [`VCH_WIDTH-1:0]         inj_rdy,
    input  logic [`VCH_WIDTH-1:0]         inj_lck,
    input  logic [`DATA_WIDTH-1:0]        ej_data_in,
    input  logic                          ej_valid_in,
    input  logic [`VCH_WIDTH_NUM-1:0]     ej_vch_in,
    output logic [`VCH_WIDTH-1:0]         ej_ack_out,
    output logic [`VCH_WIDTH-1:0]         ej_lck_out,
    output logic                          ej_valid,
    output logic [`DATA_WIDTH-1:0]        ej_data,
    output logic [`VCH_WIDTH_NUM-1:0]     ej_vch,
    input  logic                          ej_ready,
`ifdef NI_STATS_EN
    output logic [15:0]                   inj_pkt_cnt,
    output logic [15:0]                   ej_pkt_cnt,
`endif
    output logic                          ej_ovf
);

    localparam int DW  = `DATA_WIDTH;
    localparam int NV  = `VCH_WIDTH;
    localparam int VW  = `VCH_WIDTH_NUM;
    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int FD  = BUF_DEPTH * NV;
    localparam int PW  = (FD > 1) ? $clog2(FD) : 1;
    localparam int NW  = $clog2(FD + 1);
    localparam logic [3:0] RID = 4'(ROUTERID);

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_HEAD, S_BODY} state_t;

    // ---------------- injection ----------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_dst;
    logic [LEN_W-1:0]   r_rem;
    logic [VW-1:0]      r_vc;
    logic [CW-1:0]      r_credit [NV];
    logic [DW-1:0]      r_inj_data;
    logic               r_inj_valid;
    logic [VW-1:0]      r_inj_vch;

    logic               w_pkt_ready;
    logic               w_pay_ready;
    logic               w_sel_ok;
    logic [VW-1:0]      w_sel_vc;
    logic [NV-1:0]      w_send;
    logic               w_flit_vld;
    logic [DW-1:0]      w_flit;
    logic               w_pay_fire;
    logic               w_last;

    assign w_last = (r_rem == LEN_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_pkt_ready = 1'b0;
        w_pay_ready = 1'b0;
        w_sel_ok    = 1'b0;
        w_sel_vc    = '0;
        w_send      = '0;
        w_flit_vld  = 1'b0;
        w_flit      = '0;
        w_pay_fire  = 1'b0;

        // Descending scan so the lowest qualifying VC wins.
        for (int v = NV - 1; v >= 0; v--) begin
            if (inj_rdy[v] && !inj_lck[v] && (r_credit[v] != '0)) begin
                w_sel_ok = 1'b1;
                w_sel_vc = VW'(v);
            end
        end

        case (r_state)
            S_IDLE: begin
                w_pkt_ready = 1'b1;
                if (pkt_valid)
                    w_state_nxt = S_SEL;
            end
            S_SEL: begin
                if (w_sel_ok)
                    w_state_nxt = S_HEAD;
            end
            S_HEAD: begin
                w_flit_vld            = 1'b1;
                w_flit[DW-1 -: 2]     = 2'b01;
                w_flit[7:4]           = RID;
                w_flit[3:0]           = r_dst;
                w_send[r_vc]          = 1'b1;
                w_state_nxt           = S_BODY;
            end
            S_BODY: begin
                w_pay_ready = (r_credit[r_vc] != '0);
                if (pay_valid && w_pay_ready) begin
                    w_pay_fire        = 1'b1;
                    w_flit_vld        = 1'b1;
                    w_flit[DW-1 -: 2] = w_last ? 2'b10 : 2'b00;
                    w_flit[DW-3:0]    = pay_data;
                    w_send[r_vc]      = 1'b1;
                    if (w_last)
                        w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_dst       <= '0;
            r_rem       <= '0;
            r_vc        <= '0;
            r_inj_data  <= '0;
            r_inj_valid <= 1'b0;
            r_inj_vch   <= '0;
            for (int v = 0; v < NV; v++)
                r_credit[v] <= CW'(BUF_DEPTH);
        end else begin
            r_state     <= w_state_nxt;
            r_inj_valid <= w_flit_vld;
            r_inj_data  <= w_flit;
            r_inj_vch   <= w_flit_vld ? r_vc : '0;
            if (r_state == S_IDLE && pkt_valid) begin
                r_dst <= pkt_dst;
                r_rem <= (pkt_len == '0) ? LEN_W'(1) : pkt_len;
            end
            if (r_state == S_SEL && w_sel_ok)
                r_vc <= w_sel_vc;
            if (w_pay_fire)
                r_rem <= r_rem - 1'b1;
            // Ack and send together cancel; acks beyond a full buffer are ignored.
            for (int v = 0; v < NV; v++) begin
                case ({inj_ack[v], w_send[v]})
                    2'b10: if (r_credit[v] != CW'(BUF_DEPTH))
                               r_credit[v] <= r_credit[v] + 1'b1;
                    2'b01: r_credit[v] <= r_credit[v] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign pkt_ready = w_pkt_ready & reset;
    assign pay_ready = w_pay_ready & reset;
    assign inj_data  = r_inj_data;
    assign inj_valid = r_inj_valid;
    assign inj_vch   = r_inj_vch;

    // ---------------- ejection ----------------
    logic [DW-1:0]      r_mem_dat [FD];
    logic [VW-1:0]      r_mem_vch [FD];
    logic [PW-1:0]      r_wr;
    logic [PW-1:0]      r_rd;
    logic [NW-1:0]      r_cnt;
    logic [NV-1:0]      r_ack;
    logic [NV-1:0]      r_lck;
    logic               r_ovf;

    logic               w_ej_vld;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [1:0]         w_in_type;
    logic               w_pop_tail;

    assign w_ej_vld   = (r_cnt != '0);
    assign w_full     = (r_cnt == NW'(FD));
    assign w_pop      = w_ej_vld & ej_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push     = ej_valid_in & (!w_full | w_pop);
    assign w_in_type  = ej_data_in[DW-1 -: 2];
    assign w_pop_tail = w_pop & (r_mem_dat[r_rd][DW-1 -: 2] == 2'b10);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dat[r_wr] <= ej_data_in;
            r_mem_vch[r_wr] <= ej_vch_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ack <= '0;
            r_lck <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push)
                r_wr <= (r_wr == PW'(FD - 1)) ? '0 : r_wr + 1'b1;
            if (w_pop)
                r_rd <= (r_rd == PW'(FD - 1)) ? '0 : r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
            r_ack <= w_pop ? (NV'(1) << r_mem_vch[r_rd]) : '0;
            if (w_push && w_in_type == 2'b01)
                r_lck[ej_vch_in] <= 1'b1;
            else if (w_push && w_in_type == 2'b10)
                r_lck[ej_vch_in] <= 1'b0;
            if (ej_valid_in && !w_push)
                r_ovf <= 1'b1;
        end
    end

    assign ej_valid   = w_ej_vld;
    assign ej_data    = w_ej_vld ? r_mem_dat[r_rd] : '0;
    assign ej_vch     = w_ej_vld ? r_mem_vch[r_rd] : '0;
    assign ej_ack_out = r_ack;
    assign ej_lck_out = r_lck;
    assign ej_ovf     = r_ovf;

`ifdef NI_STATS_EN
    logic [15:0] r_inj_pkt_cnt;
    logic [15:0] r_ej_pkt_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_inj_pkt_cnt <= '0;
            r_ej_pkt_cnt  <= '0;
        end else begin
            if (w_pay_fire && w_last)
                r_inj_pkt_cnt <= r_inj_pkt_cnt + 1'b1;
            if (w_pop_tail)
                r_ej_pkt_cnt <= r_ej_pkt_cnt + 1'b1;
        end
    end

    assign inj_pkt_cnt = r_inj_pkt_cnt;
    assign ej_pkt_cnt  = r_ej_pkt_cnt;
`else
    logic w_unused_pop_tail;
    assign w_unused_pop_tail = w_pop_tail;
`endif

endmodule
